// File: rtl/stack_pkg.sv
// ---------------------------------------------------------------------------
// stack_pkg: shared definitions for the stack-port sequencer.
//   op_e     - execute-stage operation encoding (req_op)
//   state_e  - sequencer FSM states
//   STACK_LIMIT_DEFAULT / SP_RESET_DEFAULT - default parameter values
//   push_ovf - overflow test applied at a PUSH strobe
// ---------------------------------------------------------------------------
package stack_pkg;

  typedef enum logic [1:0] {
    OP_PUSH = 2'd0,
    OP_POP  = 2'd1,
    OP_XTHL = 2'd2,
    OP_LDSP = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    StIdle,
    StStrobe,
    StWait,
    StResp
  } state_e;

  localparam logic [15:0] STACK_LIMIT_DEFAULT = 16'hC000;
  // Memory powers up with its top at 17'h10000, which is 0 in 16 bits.
  localparam logic [15:0] SP_RESET_DEFAULT    = 16'h0000;

  // sp == 0 is the power-on top, so the wrap to 16'hFFFE is a legal push.
  function automatic logic push_ovf(input logic [15:0] sp, input logic [15:0] limit);
    return (sp != 16'h0000) && ((sp - 16'd2) < limit);
  endfunction

endpackage

// File: rtl/stack_seq_if.sv
// ---------------------------------------------------------------------------
// stack_seq_if: bundle between the execute stage, the sequencer and the
// memory stack port.
//   req_valid/req_ready/req_op/req_data  - operation request handshake
//   rsp_valid/rsp_ready/rsp_data         - response handshake
//   mem_push/mem_pop/mem_swap/mem_replace_sp/mem_wdata - strobes to memory
//   mem_rdata                            - memory read data (1-cycle latency)
// Modports: slave = sequencer view, master = execute stage + memory view.
// ---------------------------------------------------------------------------
interface stack_seq_if;

  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [15:0] req_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_data;
  logic        mem_push;
  logic        mem_pop;
  logic        mem_swap;
  logic        mem_replace_sp;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;

  modport slave (
    input  req_valid, req_op, req_data, rsp_ready, mem_rdata,
    output req_ready, rsp_valid, rsp_data,
    output mem_push, mem_pop, mem_swap, mem_replace_sp, mem_wdata
  );

  modport master (
    output req_valid, req_op, req_data, rsp_ready, mem_rdata,
    input  req_ready, rsp_valid, rsp_data,
    input  mem_push, mem_pop, mem_swap, mem_replace_sp, mem_wdata
  );

endinterface

// File: rtl/stack_seq.sv
// ---------------------------------------------------------------------------
// stack_seq: CPU-side initiator for the memory stack port. Takes one
// PUSH/POP/XTHL/LDSP at a time, issues a single one-cycle memory strobe,
// waits out the memory read latency for POP/XTHL and returns the result
// through a valid/ready response. Keeps a shadow SP and a sticky overflow.
// Ports:
//   i_clk   - clock, all state on rising edge
//   i_rst   - asynchronous active-high reset
//   io_stk  - stack_seq_if.slave (request, response, memory strobes)
//   o_sp    - shadow stack pointer
//   o_ovf   - sticky stack-overflow flag
// After reset the memory (which has no reset) may disagree with o_sp; the
// core issues LDSP before using the stack again.
// ---------------------------------------------------------------------------
module stack_seq
  import stack_pkg::*;
#(
  parameter logic [15:0] STACK_LIMIT = STACK_LIMIT_DEFAULT,
  parameter logic [15:0] SP_RESET    = SP_RESET_DEFAULT
) (
  input  logic              i_clk,
  input  logic              i_rst,
  stack_seq_if.slave        io_stk,
  output logic [15:0]       o_sp,
  output logic              o_ovf
);

  state_e      r_state, w_state_d;
  op_e         r_op, w_op_d;
  logic [15:0] r_data, w_data_d;
  logic [15:0] r_rsp_data, w_rsp_data_d;
  logic [15:0] r_sp, w_sp_d;
  logic        r_ovf, w_ovf_d;

  logic        w_push, w_pop, w_swap, w_replace_sp;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= StIdle;
      r_op       <= OP_PUSH;
      r_data     <= 16'h0000;
      r_rsp_data <= 16'h0000;
      r_sp       <= SP_RESET;
      r_ovf      <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_op       <= w_op_d;
      r_data     <= w_data_d;
      r_rsp_data <= w_rsp_data_d;
      r_sp       <= w_sp_d;
      r_ovf      <= w_ovf_d;
    end
  end

  always_comb begin
    w_state_d    = r_state;
    w_op_d       = r_op;
    w_data_d     = r_data;
    w_rsp_data_d = r_rsp_data;
    w_sp_d       = r_sp;
    w_ovf_d      = r_ovf;
    w_push       = 1'b0;
    w_pop        = 1'b0;
    w_swap       = 1'b0;
    w_replace_sp = 1'b0;

    unique case (r_state)
      StIdle: begin
        if (io_stk.req_valid) begin
          w_op_d    = op_e'(io_stk.req_op);
          w_data_d  = io_stk.req_data;
          w_state_d = StStrobe;
        end
      end

      // Exactly one strobe per operation, so the memory's replace_SP
      // priority over push/pop never comes into play.
      StStrobe: begin
        unique case (r_op)
          OP_PUSH: begin
            w_push       = 1'b1;
            w_sp_d       = r_sp - 16'd2;
            w_rsp_data_d = 16'h0000;
            w_state_d    = StResp;
            if (push_ovf(r_sp, STACK_LIMIT)) begin
              w_ovf_d = 1'b1;
            end
          end
          OP_POP: begin
            w_pop     = 1'b1;
            w_sp_d    = r_sp + 16'd2;
            w_state_d = StWait;
          end
          OP_XTHL: begin
            w_swap    = 1'b1;
            w_state_d = StWait;
          end
          OP_LDSP: begin
            w_replace_sp = 1'b1;
            w_sp_d       = r_data;
            w_rsp_data_d = 16'h0000;
            w_state_d    = StResp;
          end
          default: w_state_d = StIdle;
        endcase
      end

      // Memory output is valid the cycle after the pop/swap strobe.
      StWait: begin
        w_rsp_data_d = io_stk.mem_rdata;
        w_state_d    = StResp;
      end

      StResp: begin
        if (io_stk.rsp_ready) begin
          w_state_d = StIdle;
        end
      end

      default: w_state_d = StIdle;
    endcase
  end

  assign io_stk.req_ready      = (r_state == StIdle);
  assign io_stk.rsp_valid      = (r_state == StResp);
  assign io_stk.rsp_data       = r_rsp_data;
  assign io_stk.mem_push       = w_push;
  assign io_stk.mem_pop        = w_pop;
  assign io_stk.mem_swap       = w_swap;
  assign io_stk.mem_replace_sp = w_replace_sp;
  assign io_stk.mem_wdata      = r_data;
  assign o_sp                  = r_sp;
  assign o_ovf                 = r_ovf;

endmodule

// File: tb/tb_stack_seq.sv
// ---------------------------------------------------------------------------
// tb_stack_seq: directed bench for stack_seq with a behavioural memory
// stack port as responder. Expected values are hand-computed per vector.
// ---------------------------------------------------------------------------
module tb_stack_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [15:0] sp;
  logic        ovf;

  int n_vec = 0;
  int n_err = 0;

  stack_seq_if u_if ();

  stack_seq u_dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .io_stk (u_if),
    .o_sp   (sp),
    .o_ovf  (ovf)
  );

  always #5 clk = ~clk;

  // Behavioural memory stack port: no reset, one-cycle read latency.
  logic [15:0] m_ram [0:32767];
  logic [15:0] m_top = 16'h0000;
  logic [15:0] m_out = 16'h0000;

  function automatic logic [14:0] widx(input logic [15:0] a);
    return a[15:1];
  endfunction

  always @(posedge clk) begin
    if (u_if.mem_replace_sp) begin
      m_top <= u_if.mem_wdata;
    end else if (u_if.mem_push) begin
      m_ram[widx(m_top - 16'd2)] <= u_if.mem_wdata;
      m_top <= m_top - 16'd2;
    end else if (u_if.mem_pop) begin
      m_out <= m_ram[widx(m_top)];
      m_top <= m_top + 16'd2;
    end else if (u_if.mem_swap) begin
      m_out <= m_ram[widx(m_top)];
      m_ram[widx(m_top)] <= u_if.mem_wdata;
    end
  end

  assign u_if.mem_rdata = m_out;

  // Accept / strobe accounting.
  int n_acc = 0;
  int n_stb = 0;
  int n_coinc = 0;

  always @(posedge clk) begin
    int s;
    s = int'(u_if.mem_push) + int'(u_if.mem_pop) + int'(u_if.mem_swap)
      + int'(u_if.mem_replace_sp);
    if (!rst && u_if.req_valid && u_if.req_ready) n_acc++;
    n_stb += s;
    if (s > 1) n_coinc++;
  end

  function automatic logic [3:0] stb_vec();
    return {u_if.mem_push, u_if.mem_pop, u_if.mem_swap, u_if.mem_replace_sp};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One operation: request, strobe check, latency, optional response stall
  // with ignored req_valid pulses, handshake, final SP.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [15:0] data,
                        input int hold, input logic [3:0] exp_stb, input int exp_lat,
                        input logic [15:0] exp_rsp, input logic [15:0] exp_sp);
    int k;
    int lat;
    int a0;
    logic [15:0] d0;
    @(negedge clk);
    u_if.req_op = op;
    u_if.req_data = data;
    u_if.req_valid = 1'b1;
    u_if.rsp_ready = 1'b0;
    k = 0;
    while (!u_if.req_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    check_eq({tag, "_accept"}, 32'(k < 20), 32'd1);
    @(negedge clk);
    u_if.req_valid = 1'b0;
    check_eq({tag, "_strobe"}, 32'(stb_vec()), 32'(exp_stb));
    check_eq({tag, "_wdata"}, 32'(u_if.mem_wdata), 32'(data));
    check_eq({tag, "_busy"}, 32'(u_if.req_ready), 32'd0);
    @(negedge clk);
    check_eq({tag, "_strobe_off"}, 32'(stb_vec()), 32'd0);
    lat = 2;
    while (!u_if.rsp_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    check_eq({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check_eq({tag, "_rsp_data"}, 32'(u_if.rsp_data), 32'(exp_rsp));
    d0 = u_if.rsp_data;
    a0 = n_acc;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      u_if.req_valid = (i % 2 == 0);
      check_eq({tag, "_hold_valid"}, 32'(u_if.rsp_valid), 32'd1);
      check_eq({tag, "_hold_data"}, 32'(u_if.rsp_data), 32'(d0));
      check_eq({tag, "_hold_ready"}, 32'(u_if.req_ready), 32'd0);
      check_eq({tag, "_hold_strobe"}, 32'(stb_vec()), 32'd0);
    end
    u_if.req_valid = 1'b0;
    u_if.rsp_ready = 1'b1;
    @(negedge clk);
    u_if.rsp_ready = 1'b0;
    check_eq({tag, "_no_accept"}, 32'(n_acc - a0), 32'd0);
    check_eq({tag, "_idle"}, 32'({u_if.req_ready, u_if.rsp_valid}), 32'b10);
    check_eq({tag, "_sp"}, 32'(sp), 32'(exp_sp));
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_req_ready"}, 32'(u_if.req_ready), 32'd1);
    check_eq({tag, "_rsp_valid"}, 32'(u_if.rsp_valid), 32'd0);
    check_eq({tag, "_rsp_data"}, 32'(u_if.rsp_data), 32'd0);
    check_eq({tag, "_sp"}, 32'(sp), 32'h0000);
    check_eq({tag, "_ovf"}, 32'(ovf), 32'd0);
    check_eq({tag, "_strobes"}, 32'(stb_vec()), 32'd0);
    check_eq({tag, "_wdata"}, 32'(u_if.mem_wdata), 32'd0);
  endtask

  initial begin
    int k;
    int a0;
    int s0;
    u_if.req_valid = 1'b0;
    u_if.req_op = 2'd0;
    u_if.req_data = 16'h0000;
    u_if.rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_state("reset");
    rst = 1'b0;

    // PUSH at power-on top wraps to FFFE without overflow.
    run_op("push1234", 2'd0, 16'h1234, 0, 4'b1000, 2, 16'h0000, 16'hFFFE);
    check_eq("push1234_ovf", 32'(ovf), 32'd0);
    run_op("pop1234", 2'd1, 16'h0000, 0, 4'b0100, 3, 16'h1234, 16'h0000);

    // LDSP / PUSH / XTHL / POP round trip.
    run_op("ldsp_c100", 2'd3, 16'hC100, 0, 4'b0001, 2, 16'h0000, 16'hC100);
    run_op("push_aaaa", 2'd0, 16'hAAAA, 0, 4'b1000, 2, 16'h0000, 16'hC0FE);
    run_op("xthl_5555", 2'd2, 16'h5555, 0, 4'b0010, 3, 16'hAAAA, 16'hC0FE);
    run_op("pop_5555", 2'd1, 16'h0000, 0, 4'b0100, 3, 16'h5555, 16'hC100);
    check_eq("c100_ovf", 32'(ovf), 32'd0);

    // Response stalled 5 cycles with req_valid pulses in the window.
    run_op("push_beef", 2'd0, 16'hBEEF, 0, 4'b1000, 2, 16'h0000, 16'hC0FE);
    run_op("pop_stall", 2'd1, 16'h0000, 5, 4'b0100, 3, 16'hBEEF, 16'hC100);

    // Overflow below the limit; sticky across a POP.
    run_op("ldsp_c001", 2'd3, 16'hC001, 0, 4'b0001, 2, 16'h0000, 16'hC001);
    run_op("push_ovf", 2'd0, 16'h7777, 0, 4'b1000, 2, 16'h0000, 16'hBFFF);
    check_eq("push_ovf_flag", 32'(ovf), 32'd1);
    run_op("pop_ovf", 2'd1, 16'h0000, 0, 4'b0100, 3, 16'h7777, 16'hC001);
    check_eq("ovf_sticky", 32'(ovf), 32'd1);

    // Asynchronous reset in the middle of a POP's WAIT cycle.
    @(negedge clk);
    u_if.req_op = 2'd1;
    u_if.req_valid = 1'b1;
    k = 0;
    while (!u_if.req_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    u_if.req_valid = 1'b0;
    check_eq("rst_pop_strobe", 32'(stb_vec()), 32'b0100);
    @(negedge clk);
    #1 rst = 1'b1;
    #1 check_reset_state("midwait_reset");
    @(negedge clk);
    rst = 1'b0;

    // Resync memory, then back-to-back PUSHes with req_valid held high.
    run_op("ldsp_c200", 2'd3, 16'hC200, 0, 4'b0001, 2, 16'h0000, 16'hC200);
    a0 = n_acc;
    s0 = n_stb;
    u_if.req_op = 2'd0;
    u_if.req_data = 16'h1000;
    u_if.req_valid = 1'b1;
    u_if.rsp_ready = 1'b1;
    repeat (15) @(negedge clk);
    u_if.req_valid = 1'b0;
    k = 0;
    while (!u_if.req_ready && k < 10) begin
      @(negedge clk);
      k++;
    end
    u_if.rsp_ready = 1'b0;
    check_eq("b2b_accepts", 32'(n_acc - a0), 32'd5);
    check_eq("b2b_strobes", 32'(n_stb - s0), 32'd5);
    check_eq("b2b_sp", 32'(sp), 32'hC1F6);
    check_eq("no_coincident", 32'(n_coinc), 32'd0);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/stack_seq.md
Name: stack_seq

Overview:
- CPU-side initiator for the memory block's stack port; the memory is the responder.
- Accepts one stack operation at a time from the execute stage: PUSH, POP, XTHL or LDSP (SPHL/LXI SP).
- Sequences the memory strobes (push, pop, swap, replace_SP) and waits out the memory's one-cycle read latency.
- Keeps a shadow SP and returns popped/exchanged words through a valid/ready response.

Parameters:
STACK_LIMIT, 16'hC000, lowest legal stack address; a push that would leave sp below it raises ovf
SP_RESET, 16'h0000, shadow SP after reset; equals the memory's power-on top 17'h10000 mod 2^16

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-high reset
req_valid  in  1  execute stage presents an operation
req_ready  out  1  controller can accept an operation this cycle
req_op  in  2  0=PUSH, 1=POP, 2=XTHL, 3=LDSP
req_data  in  16  word to push, exchange value, or new SP
rsp_valid  out  1  operation complete, rsp_data valid
rsp_ready  in  1  execute stage accepts the response
rsp_data  out  16  popped or old top-of-stack word; 0 for PUSH/LDSP
sp  out  16  shadow stack pointer
ovf  out  1  sticky stack-overflow flag
mem_push  out  1  to memory push
mem_pop  out  1  to memory pop
mem_swap  out  1  to memory swap
mem_replace_sp  out  1  to memory replace_SP
mem_wdata  out  16  to memory input_data
mem_rdata  in  16  from memory out; valid the cycle after a pop or swap strobe

Behaviour:
- Reset (async, any state): state=IDLE; req_ready=1; rsp_valid=0; rsp_data=0; sp=SP_RESET; ovf=0; all mem strobes 0; mem_wdata=0.
- The memory has no reset, so a reset between a strobe and its response can desync sp. The core must issue LDSP after any reset before using the stack.
- States: IDLE, STROBE, WAIT, RESP.
- IDLE: req_ready=1. When req_valid is high, latch op and data and go to STROBE. req_ready drops the next cycle and stays 0 until back in IDLE.
- STROBE: exactly one strobe high for exactly one cycle; mem_wdata = latched data.
  - PUSH: mem_push; sp <= sp-2.
  - POP: mem_pop; sp <= sp+2.
  - XTHL: mem_swap; sp unchanged.
  - LDSP: mem_replace_sp; sp <= data.
  - POP and XTHL go to WAIT; PUSH and LDSP go to RESP with rsp_data=0.
- WAIT: capture mem_rdata into rsp_data; go to RESP.
- RESP: rsp_valid=1 and rsp_data held stable until rsp_ready is high. The handshake cycle goes to IDLE, so the next request is accepted no earlier than the following cycle.
- Latency from accept to rsp_valid: 2 cycles for PUSH/LDSP, 3 for POP/XTHL. Throughput is one operation per 3 or 4 cycles.
- Never more than one strobe per cycle. The memory's replace_SP precedence over push/pop is therefore never exercised.
- SP arithmetic is 16-bit modulo:
  - POP at sp=16'hFFFE gives 16'h0000.
  - PUSH at sp=16'h0000 gives 16'hFFFE and is legal (power-on top); no ovf.
- ovf: set at a PUSH strobe when sp != 0 and sp-2 < STACK_LIMIT. The push is still performed. Cleared only by reset.
- POP is not bounds-checked; underflow past 16'hFFFE wraps silently.
- A req_valid held high while busy is ignored. The request must be held until req_ready && req_valid.

Decomposition:
- Shared package stack_pkg:
  - op encodings OP_PUSH/OP_POP/OP_XTHL/OP_LDSP;
  - state encoding;
  - STACK_LIMIT default.
- No sub-module; a single FSM plus sp register fits in about 150 lines.
- Bench instantiates stack_seq with the memory block as the responder.

Test Plan:
- reset; PUSH 16'h1234 -> mem_push one cycle, mem_wdata=16'h1234, sp=16'hFFFE, rsp_valid 2 cycles after accept, rsp_data=0, ovf=0.
- After that PUSH, POP with rsp_ready=1 -> mem_pop one cycle, rsp_data=16'h1234 3 cycles after accept, sp=16'h0000.
- LDSP 16'hC100; PUSH 16'hAAAA; XTHL 16'h5555 -> rsp_data=16'hAAAA, sp=16'hC0FE; subsequent POP returns 16'h5555.
- LDSP 16'hC001; PUSH -> sp=16'hBFFF, ovf=1; ovf stays 1 after a POP; async reset mid-WAIT -> all outputs 0 immediately, sp=16'h0000.
- rsp_ready held 0 for 5 cycles after POP -> rsp_valid and rsp_data stable, req_ready=0, no further strobes; req_valid pulses during this window are ignored.
- Back-to-back PUSHes with req_valid held high -> exactly one strobe per accepted request, sp decreases by 2 each; strobes are never coincident.
